pcm_pwm_player: RTL and testbench

Playback stage directly downstream of the microphone capture block: drains PCM samples from the capture buffer's read port and renders them as a PWM audio signal for the on-board amplifier. A sample-period FSM fetches one word per `REPEAT` PWM periods with a one-cycle-latency read handshake. It prefetches into a staging register so that duty updates land exactly on PWM period boundaries. Underruns hold the last sample and are flagged.

---
 rtl/pcm_pwm_player.sv | 112 +++++++++++
 tb/tb_pcm_pwm_player.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_pwm_player.sv
// PCM-to-PWM playback stage: fetches one sample per REPEAT PWM periods from the capture buffer.
// Define PCM_SIGNED_EN to treat fifo_data as two's complement (MSB inverted on capture).
//
// state   | meaning
// IDLE    | staging empty, waiting for enable and a non-empty buffer
// READ    | fifo_rd strobe cycle
// CAPTURE | read data valid, written into the staging register
// FULL    | staged word waits for the next sample boundary
module pcm_pwm_player #(
  parameter int DATA_W = 8,
  parameter int REPEAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              audio_pwm,
  output logic              audio_sd,
  output logic              underrun
);

  localparam logic [DATA_W-1:0] CNT_MAX  = '1;
  localparam logic [DATA_W-1:0] MID      = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [7:0]        REP_LAST = 8'(REPEAT - 1);

  typedef enum logic [1:0] {IDLE, READ, CAPTURE, FULL} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] cnt;
  logic [DATA_W-1:0] duty;
  logic [DATA_W-1:0] stage;
  logic [DATA_W-1:0] cap_word;
  logic [7:0]        rep;
  logic              stage_valid;
  logic              drop;
  logic              period_end;
  logic              sample_end;

  assign period_end = (cnt == CNT_MAX);
  assign sample_end = en && period_end && (rep == REP_LAST);

`ifdef PCM_SIGNED_EN
  assign cap_word = fifo_data ^ MID;
`else
  assign cap_word = fifo_data;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fifo_rd   = 1'b0;
    case (state)
      IDLE:    if (en && !fifo_empty && !stage_valid) state_nxt = READ;
      READ: begin
        fifo_rd   = 1'b1;
        state_nxt = CAPTURE;
      end
      // a bus cycle started before en dropped still completes, but its word is discarded
      CAPTURE: state_nxt = (en && !drop) ? FULL : IDLE;
      FULL:    if (!en || sample_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      rep         <= '0;
      duty        <= MID;
      stage       <= '0;
      stage_valid <= 1'b0;
      drop        <= 1'b0;
      underrun    <= 1'b0;
      audio_pwm   <= 1'b0;
      audio_sd    <= 1'b0;
    end else begin
      audio_sd  <= en;
      audio_pwm <= en && (cnt < duty);
      if (state == READ) drop <= !en;
      if (!en) begin
        cnt         <= '0;
        rep         <= '0;
        duty        <= MID;
        stage_valid <= 1'b0;
        underrun    <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
        if (period_end) rep <= (rep == REP_LAST) ? 8'd0 : rep + 8'd1;
        if (sample_end) begin
          if (stage_valid) begin
            duty        <= stage;
            stage_valid <= 1'b0;
          end else begin
            underrun    <= 1'b1;
          end
        end
        // a capture coinciding with a sample boundary is staged for the following one
        if (state == CAPTURE && !drop) begin
          stage       <= cap_word;
          stage_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pcm_pwm_player.sv
// Scoreboard bench for pcm_pwm_player: expected PWM high-counts per period and fifo_rd cycles
// are queued by the stimulus and checked by independent monitors.
module tb_pcm_pwm_player;

  localparam int PER = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty;
  logic       fifo_rd, audio_pwm, audio_sd, underrun;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_pwm[$];
  int exp_rd[$];

  logic [7:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;

  pcm_pwm_player #(.DATA_W(8), .REPEAT(4)) dut (
    .clk(clk), .reset(reset), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(fifo_rd), .audio_pwm(audio_pwm), .audio_sd(audio_sd), .underrun(underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_data <= mem[rd_ptr[3:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int duty_of(input logic [7:0] s);
`ifdef PCM_SIGNED_EN
    return int'(s ^ 8'h80);
`else
    return int'(s);
`endif
  endfunction

  task automatic push(input logic [7:0] v);
    mem[wr_ptr[3:0]] = v;
    wr_ptr++;
  endtask

  task automatic push_pwm(input int n, input int high);
    for (int i = 0; i < n; i++) exp_pwm.push_back(high);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int limit);
    int t;
    t = 0;
    while (exp_pwm.size() > 0 && t < limit) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_pwm.size() > 0) begin
      check("pwm_timeout", exp_pwm.size(), 0);
      exp_pwm.delete();
    end
  endtask

  // PWM monitor: windows start on the first output produced after en is seen high
  logic en_q;
  int   pidx = 0;
  int   psum = 0;
  int   pnum = 0;
  int   pexp = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) en_q <= 1'b0;
    else        en_q <= en;
  end

  always @(negedge clk) begin
    if (!en_q) begin
      pidx = 0;
      psum = 0;
    end else begin
      psum += int'(audio_pwm);
      pidx++;
      if (pidx == PER) begin
        if (exp_pwm.size() > 0) begin
          pexp = exp_pwm.pop_front();
          check($sformatf("pwm_period%0d", pnum), psum, pexp);
          pnum++;
        end
        pidx = 0;
        psum = 0;
      end
    end
  end

  // read-strobe monitor
  logic prev_rd = 1'b0;
  int   rd_start = 0;

  always @(negedge clk) begin
    if (fifo_rd && !prev_rd) begin
      rd_start = cyc;
      check("rd_nonempty", int'(fifo_empty), 0);
      if (exp_rd.size() == 0) check("rd_unexpected", cyc, -1);
      else                    check("rd_cycle", cyc, exp_rd.pop_front());
    end
    if (!fifo_rd && prev_rd) check("rd_width", cyc - rd_start, 1);
    prev_rd = fifo_rd;
  end

  int n0, n1, n3;

  initial begin
    // reset held, then idle with en low
    repeat (3) @(posedge clk);
    #1;
    check("rst_fifo_rd", int'(fifo_rd), 0);
    check("rst_pwm", int'(audio_pwm), 0);
    check("rst_sd", int'(audio_sd), 0);
    check("rst_underrun", int'(underrun), 0);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("idle_pwm", int'(audio_pwm), 0);
    check("idle_sd", int'(audio_sd), 0);
    check("idle_underrun", int'(underrun), 0);

    // steady playback, underrun, late data, extremes
    push(8'h40);
    push(8'hC0);
    n0 = cyc;
    en = 1'b1;
    exp_rd.push_back(n0 + 1);
    exp_rd.push_back(n0 + 1025);
    push_pwm(4, 128);
    push_pwm(4, duty_of(8'h40));
    push_pwm(4, duty_of(8'hC0));
    push_pwm(4, duty_of(8'hC0));
    push_pwm(4, duty_of(8'hC0));
    push_pwm(4, duty_of(8'h00));
    push_pwm(4, duty_of(8'hFF));
    wait_until(n0 + 2);
    check("sd_on", int'(audio_sd), 1);
    wait_until(n0 + 3000);
    check("underrun_before", int'(underrun), 0);
    wait_until(n0 + 3100);
    check("underrun_set", int'(underrun), 1);
    wait_until(n0 + 4196);
    push(8'h00);
    push(8'hFF);
    exp_rd.push_back(n0 + 4197);
    exp_rd.push_back(n0 + 5121);
    drain(4000);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("en_low_underrun", int'(underrun), 0);
    check("en_low_sd", int'(audio_sd), 0);
    check("en_low_pwm", int'(audio_pwm), 0);

    // en drops during READ: word is consumed but discarded, duty back at midscale
    push(8'h10);
    n1 = cyc;
    en = 1'b1;
    exp_rd.push_back(n1 + 1);
    wait_until(n1 + 1);
    en = 1'b0;
    wait_until(n1 + 6);
    en = 1'b1;
    push_pwm(8, 128);
    drain(3000);
    check("drop_underrun", int'(underrun), 1);
    check("drop_consumed", int'(fifo_empty), 1);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset asserted while fifo_rd is high
    push(8'h22);
    n3 = cyc;
    en = 1'b1;
    wait_until(n3 + 1);
    check("rd_before_reset", int'(fifo_rd), 1);
    reset = 1'b0;
    #1;
    check("async_rst_fifo_rd", int'(fifo_rd), 0);
    check("async_rst_pwm", int'(audio_pwm), 0);
    check("async_rst_sd", int'(audio_sd), 0);
    check("async_rst_underrun", int'(underrun), 0);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_pwm", int'(audio_pwm), 0);
    check("post_rst_sd", int'(audio_sd), 0);
    check("post_rst_fifo_rd", int'(fifo_rd), 0);

    check("rd_missing", exp_rd.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
